// File: rtl/chip8_sprite_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : chip8_sprite_engine_if
//  Purpose  : Command, sprite-memory and framebuffer-RAM signals of the
//             CHIP-8 sprite draw engine, bundled with master/slave views.
//  Revision : 1.0  initial release
// ============================================================================
interface chip8_sprite_engine_if #(
    parameter int DISP_W   = 64,
    parameter int DISP_H   = 32,
    parameter int MAX_ROWS = 16
);
    localparam int XW = $clog2(DISP_W);
    localparam int YW = $clog2(DISP_H);
    localparam int NW = $clog2(MAX_ROWS) + 1;

    // command side (instruction decoder)
    logic              start;
    logic              op;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [NW-1:0]     n;
    logic              busy;
    logic              done;
    logic              collision;

    // sprite memory side
    logic              spr_re;
    logic [NW-2:0]     spr_addr;
    logic [7:0]        spr_rdata;

    // framebuffer RAM side
    logic              fb_re;
    logic [YW-1:0]     fb_addr;
    logic [DISP_W-1:0] fb_rdata;
    logic              fb_we;
    logic [DISP_W-1:0] fb_wdata;

    // engine view
    modport slave (
        input  start, op, x, y, n, spr_rdata, fb_rdata,
        output busy, done, collision, spr_re, spr_addr,
               fb_re, fb_addr, fb_we, fb_wdata
    );

    // decoder / memory-model view
    modport master (
        output start, op, x, y, n, spr_rdata, fb_rdata,
        input  busy, done, collision, spr_re, spr_addr,
               fb_re, fb_addr, fb_we, fb_wdata
    );
endinterface
`default_nettype wire

// File: rtl/chip8_sprite_engine.sv
`default_nettype none
// ============================================================================
//  Module   : chip8_sprite_engine
//  Purpose  : Row-serial read-modify-write sprite sequencer (DXYN) and
//             screen clear (00E0) for a row-organised framebuffer RAM.
//  Revision : 1.0  initial release
// ============================================================================
module chip8_sprite_engine #(
    parameter int DISP_W   = 64,
    parameter int DISP_H   = 32,
    parameter int MAX_ROWS = 16,
    parameter int CLIP     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chip8_sprite_engine_if.slave  bus
);
    localparam int XW = $clog2(DISP_W);
    localparam int YW = $clog2(DISP_H);
    localparam int NW = $clog2(MAX_ROWS) + 1;
    localparam int SW = NW - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [NW-1:0]     n_q;
    logic [NW-1:0]     row_q;
    logic              busy_q;
    logic              done_q;
    logic              coll_q;
    logic              spr_re_q;
    logic [SW-1:0]     spr_addr_q;
    logic              fb_re_q;
    logic              fb_we_q;
    logic [YW-1:0]     fb_addr_q;

    logic [NW-1:0]     n_sat_d;
    logic [NW-1:0]     row_d;
    logic [YW:0]       row_sum_d;
    logic              row_clip_d;
    logic [YW-1:0]     nxt_addr_d;
    logic [DISP_W-1:0] mask_d;
    logic              hit_d;

    assign n_sat_d    = (bus.n > NW'(MAX_ROWS)) ? NW'(MAX_ROWS) : bus.n;
    assign row_d      = row_q + 1'b1;
    // Unwrapped target row; bit YW set means the row lies below the display.
    assign row_sum_d  = {1'b0, y_q} + (YW+1)'(row_q);
    assign row_clip_d = (CLIP != 0) && (row_sum_d >= (YW+1)'(DISP_H));
    // Truncation gives the vertical wrap for free (DISP_H is a power of two).
    assign nxt_addr_d = y_q + YW'(row_d);

    // Spread the sprite byte across the row word: column c lives at bit
    // DISP_W-1-c, which for a power-of-two width is simply ~c.
    always_comb begin : p_mask
        logic [XW:0] col;
        col    = '0;
        mask_d = '0;
        for (int i = 0; i < 8; i++) begin
            col = {1'b0, x_q} + (XW+1)'(i);
            if ((CLIP == 0) || !col[XW]) begin
                mask_d[~col[XW-1:0]] = bus.spr_rdata[3'(7 - i)];
            end
        end
    end

    assign hit_d = |(bus.fb_rdata & mask_d);

    // Write data is only meaningful in an unclipped WRITE slot; zero elsewhere
    // so that CLEAR writes zeros and reset forces the bus to 0.
    assign bus.fb_wdata  = (state_q == WRITE && fb_we_q) ? (bus.fb_rdata ^ mask_d) : '0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.collision = coll_q;
    assign bus.spr_re    = spr_re_q;
    assign bus.spr_addr  = spr_addr_q;
    assign bus.fb_re     = fb_re_q;
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_addr   = fb_addr_q;

    // Command sequencer with registered memory strobes and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            n_q        <= '0;
            row_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            coll_q     <= 1'b0;
            spr_re_q   <= 1'b0;
            spr_addr_q <= '0;
            fb_re_q    <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        x_q    <= bus.x;
                        y_q    <= bus.y;
                        n_q    <= n_sat_d;
                        row_q  <= '0;
                        coll_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.op) begin
                            state_q   <= CLEAR;
                            fb_we_q   <= 1'b1;
                            fb_addr_q <= '0;
                        end else if (n_sat_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            spr_re_q   <= 1'b1;
                            spr_addr_q <= '0;
                            fb_re_q    <= 1'b1;
                            fb_addr_q  <= bus.y;
                        end
                    end
                end
                FETCH: begin
                    state_q  <= WRITE;
                    spr_re_q <= 1'b0;
                    fb_re_q  <= 1'b0;
                    // A clipped row keeps its slot but never writes.
                    fb_we_q  <= !row_clip_d;
                end
                WRITE: begin
                    fb_we_q <= 1'b0;
                    if (fb_we_q && hit_d) begin
                        coll_q <= 1'b1;
                    end
                    if (row_d == n_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= FETCH;
                        row_q      <= row_d;
                        spr_re_q   <= 1'b1;
                        spr_addr_q <= row_d[SW-1:0];
                        fb_re_q    <= 1'b1;
                        fb_addr_q  <= nxt_addr_d;
                    end
                end
                CLEAR: begin
                    if (fb_addr_q == YW'(DISP_H - 1)) begin
                        fb_we_q <= 1'b0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        fb_addr_q <= fb_addr_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
